// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM host-port arbiter.
// No logic; default widths match the SDRAM/VGA640 controller host port.
package sdram_arb_pkg;

   localparam int DEF_ADDR_W = 22;
   localparam int DEF_DATA_W = 16;
   localparam int CNT_W      = 8;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_ACCEPT,
      ST_WAIT_DONE,
      ST_RESP
   } arb_state_e;

   function automatic logic other_port(input logic port);
      return ~port;
   endfunction

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester ports A/B plus controller host port, bundled for the arbiter.
// slave is the arbiter's view; master is the requesters and controller side.
interface sdram_port_arbiter_if import sdram_arb_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();
   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata;
   logic              a_ack;
   logic [DATA_W-1:0] a_rdata;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata;
   logic              b_ack;
   logic [DATA_W-1:0] b_rdata;

   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rdwr;
   logic              mem_strobe;
   logic              mem_lock;

   logic              busy;
   logic              grant_b;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_ack, a_rdata,
      input  b_req, b_we, b_addr, b_wdata,
      output b_ack, b_rdata,
      output mem_address, mem_wdata, mem_rdwr, mem_strobe,
      input  mem_rdata, mem_lock,
      output busy, grant_b
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_ack, a_rdata,
      output b_req, b_we, b_addr, b_wdata,
      input  b_ack, b_rdata,
      input  mem_address, mem_wdata, mem_rdwr, mem_strobe,
      output mem_rdata, mem_lock,
      input  busy, grant_b
   );

endinterface

// File: rtl/sdram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin pick: pointer side wins a tie, a lone requester always wins.
// Purely combinational; the pointer register is owned by the parent.
module rr_arbiter2 import sdram_arb_pkg::*; (
   input  logic req_a,
   input  logic req_b,
   input  logic ptr,
   output logic vld,
   output logic win
);

   always_comb begin
      vld = req_a | req_b;
      win = PORT_A;
      if (req_a && req_b) begin
         win = ptr;
      end else if (req_b) begin
         win = PORT_B;
      end
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller host port between requesters A and B, round-robin; ack 4 cycles after grant minimum.
// Requests wait while mem_lock is high in IDLE; requesters hold req until their one-cycle ack.
module sdram_port_arbiter import sdram_arb_pkg::*; #(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int ACCEPT_TIMEOUT = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   sdram_port_arbiter_if.slave bus
);

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEPT_TIMEOUT - 1);

   arb_state_e        state_q, state_d;
   logic              ptr_q, ptr_d;
   logic              grant_b_q, grant_b_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   cmd_t              cmd_q, cmd_d;
   logic              strobe_q, strobe_d;
   logic              a_ack_q, a_ack_d;
   logic              b_ack_q, b_ack_d;
   logic              busy_q, busy_d;
   logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
   logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

   cmd_t cmd_a;
   cmd_t cmd_b;
   logic arb_vld;
   logic arb_win;
   logic capture;

   assign cmd_a = {bus.a_we, bus.a_addr, bus.a_wdata};
   assign cmd_b = {bus.b_we, bus.b_addr, bus.b_wdata};

   rr_arbiter2 u_rr (
      .req_a (bus.a_req),
      .req_b (bus.b_req),
      .ptr   (ptr_q),
      .vld   (arb_vld),
      .win   (arb_win)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_b_d = grant_b_q;
      cnt_d     = cnt_q;
      cmd_d     = cmd_q;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      capture   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!bus.mem_lock && arb_vld) begin
               grant_b_d = arb_win;
               cmd_d     = (arb_win == PORT_B) ? cmd_b : cmd_a;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            state_d = ST_WAIT_ACCEPT;
         end
         ST_WAIT_ACCEPT: begin
            // A rising lock takes precedence over the timeout in the same cycle.
            if (bus.mem_lock) begin
               state_d = ST_WAIT_DONE;
            end else if (cnt_q == CNT_LAST) begin
               capture = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            if (!bus.mem_lock) begin
               capture = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            ptr_d   = other_port(grant_b_q);
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (capture && !cmd_q.we) begin
         if (grant_b_q == PORT_B) begin
            b_rdata_d = bus.mem_rdata;
         end else begin
            a_rdata_d = bus.mem_rdata;
         end
      end

      // Outputs are decoded from the next state so they leave the flops aligned with it.
      strobe_d = (state_d == ST_ISSUE);
      busy_d   = (state_d != ST_IDLE);
      a_ack_d  = (state_d == ST_RESP) && (grant_b_d == PORT_A);
      b_ack_d  = (state_d == ST_RESP) && (grant_b_d == PORT_B);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         ptr_q     <= PORT_A;
         grant_b_q <= 1'b0;
         cnt_q     <= '0;
         cmd_q     <= '0;
         strobe_q  <= 1'b0;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         busy_q    <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         grant_b_q <= grant_b_d;
         cnt_q     <= cnt_d;
         cmd_q     <= cmd_d;
         strobe_q  <= strobe_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
         busy_q    <= busy_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end

   assign bus.mem_address = cmd_q.addr;
   assign bus.mem_wdata   = cmd_q.wdata;
   assign bus.mem_rdwr    = cmd_q.we;
   assign bus.mem_strobe  = strobe_q;
   assign bus.a_ack       = a_ack_q;
   assign bus.b_ack       = b_ack_q;
   assign bus.a_rdata     = a_rdata_q;
   assign bus.b_rdata     = b_rdata_q;
   assign bus.busy        = busy_q;
   assign bus.grant_b     = grant_b_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Random two-requester traffic against a transaction-level arbiter and controller model.
// Includes a 20-cycle lock hold, accept timeouts, dropped requests and a reset in WAIT_DONE.
module tb_sdram_port_arbiter;

   localparam int AW = 22;
   localparam int DW = 16;
   localparam int TO = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   sdram_port_arbiter #(
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .ACCEPT_TIMEOUT (TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   // Transaction-level model state
   bit            inflight, busy_m, owner, to_mode, rr, force_hold;
   int            ack_cyc, cap_cyc, lock_lo, lock_hi, lock_hold, last_strobe, n_done;
   logic [DW-1:0] cap_val;
   logic [DW-1:0] rd_m [2];
   bit            pend [2];
   bit            granted [2];
   bit            dropped [2];
   bit            en [2];
   int            gap [2];
   logic          f_we [2];
   logic [AW-1:0] f_addr [2];
   logic [DW-1:0] f_wd [2];
   logic [DW-1:0] mem [int];

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
      if (mem.exists(int'(a))) return mem[int'(a)];
      return a[DW-1:0] ^ 16'hC35A;
   endfunction

   function automatic logic [AW-1:0] rnd_addr();
      case ($urandom_range(0, 3))
         0:       return '1;
         1:       return '0;
         2:       return AW'($urandom_range(0, 15));
         default: return AW'($urandom);
      endcase
   endfunction

   task automatic model_reset();
      inflight   = 1'b0;
      busy_m     = 1'b0;
      rr         = 1'b0;
      force_hold = 1'b0;
      for (int p = 0; p < 2; p++) begin
         rd_m[p]    = '0;
         granted[p] = 1'b0;
         dropped[p] = 1'b0;
      end
   endtask

   task automatic drive_reqs();
      bus.a_req   = pend[0] && !(granted[0] && dropped[0]);
      bus.a_we    = f_we[0];
      bus.a_addr  = f_addr[0];
      bus.a_wdata = f_wd[0];
      bus.b_req   = pend[1] && !(granted[1] && dropped[1]);
      bus.b_we    = f_we[1];
      bus.b_addr  = f_addr[1];
      bus.b_wdata = f_wd[1];
   endtask

   // One cycle: observe at negedge, check against the model, then drive the next inputs.
   task automatic step();
      logic exp_strobe, win, ack_now, busy_now;
      @(negedge clk);
      cyc++;

      // A grant happens at an edge where the arbiter was idle, lock low, and someone requesting.
      exp_strobe = rst_n && !busy_m && !bus.mem_lock && (bus.a_req || bus.b_req);
      chk_eq("strobe", 32'(bus.mem_strobe), 32'(exp_strobe));
      if (bus.mem_strobe) begin
         if (last_strobe >= 0) chk_eq("strobe_gap_ge5", 32'(cyc - last_strobe >= 5), 32'd1);
         last_strobe = cyc;
      end

      if (exp_strobe) begin
         win = (bus.a_req && bus.b_req) ? rr : bus.b_req;
         chk_eq("grant_b",     32'(bus.grant_b),     32'(win));
         chk_eq("mem_address", 32'(bus.mem_address), 32'(f_addr[win]));
         chk_eq("mem_wdata",   32'(bus.mem_wdata),   32'(f_wd[win]));
         chk_eq("mem_rdwr",    32'(bus.mem_rdwr),    32'(f_we[win]));
         inflight     = 1'b1;
         owner        = win;
         granted[win] = 1'b1;
         dropped[win] = ($urandom_range(0, 3) == 0);
         cap_val      = mem_rd(f_addr[win]);
         to_mode      = 1'b0;
         if (force_hold && win == 1'b0) begin
            lock_lo = cyc + 1;
            lock_hi = cyc + 12;
         end else if ($urandom_range(0, 6) == 0) begin
            to_mode = 1'b1;
         end else begin
            lock_lo = cyc + 1 + int'($urandom_range(0, TO - 1));
            lock_hi = lock_lo + int'($urandom_range(0, 5));
         end
         // Timeout: TO cycles waiting for lock, capture in the last; else capture on the lock fall.
         cap_cyc = to_mode ? cyc + TO : lock_hi + 1;
         ack_cyc = cap_cyc + 1;
      end

      ack_now  = inflight && (cyc == ack_cyc);
      busy_now = inflight;
      chk_eq("a_ack", 32'(bus.a_ack), 32'(ack_now && owner == 1'b0));
      chk_eq("b_ack", 32'(bus.b_ack), 32'(ack_now && owner == 1'b1));
      chk_eq("busy",  32'(bus.busy),  32'(busy_now));
      if (ack_now) begin
         if (!f_we[owner]) rd_m[owner] = cap_val;
         rr             = ~owner;
         pend[owner]    = 1'b0;
         granted[owner] = 1'b0;
         gap[owner]     = int'($urandom_range(0, 3));
         n_done++;
         inflight       = 1'b0;
      end
      busy_m = busy_now;
      chk_eq("a_rdata", 32'(bus.a_rdata), 32'(rd_m[0]));
      chk_eq("b_rdata", 32'(bus.b_rdata), 32'(rd_m[1]));

      // Controller model
      if (inflight) begin
         bus.mem_lock = !to_mode && (cyc >= lock_lo) && (cyc <= lock_hi);
         if (cyc == cap_cyc) begin
            bus.mem_rdata = cap_val;
            if (f_we[owner] && !to_mode) mem[int'(f_addr[owner])] = f_wd[owner];
         end else begin
            bus.mem_rdata = DW'($urandom);
         end
      end else begin
         bus.mem_rdata = DW'($urandom);
         if (lock_hold > 0) begin
            bus.mem_lock = 1'b1;
            lock_hold--;
         end else begin
            bus.mem_lock = ($urandom_range(0, 7) == 0);
         end
      end

      // Requester models
      for (int p = 0; p < 2; p++) begin
         if (!pend[p]) begin
            if (gap[p] > 0) begin
               gap[p]--;
            end else if (en[p]) begin
               pend[p]   = 1'b1;
               f_we[p]   = 1'($urandom_range(0, 1));
               f_addr[p] = rnd_addr();
               f_wd[p]   = DW'($urandom);
            end
         end
      end
      drive_reqs();
   endtask

   initial begin
      bit hit, seen;
      last_strobe = -1;
      n_done      = 0;
      lock_hold   = 0;
      for (int p = 0; p < 2; p++) begin
         pend[p]   = 1'b0;
         en[p]     = 1'b0;
         gap[p]    = 0;
         f_we[p]   = 1'b0;
         f_addr[p] = '0;
         f_wd[p]   = '0;
      end
      bus.mem_lock  = 1'b0;
      bus.mem_rdata = '0;
      drive_reqs();
      model_reset();

      repeat (3) step();
      chk_eq("rst_mem_address", 32'(bus.mem_address), 32'd0);
      chk_eq("rst_mem_wdata",   32'(bus.mem_wdata),   32'd0);
      chk_eq("rst_mem_rdwr",    32'(bus.mem_rdwr),    32'd0);
      chk_eq("rst_grant_b",     32'(bus.grant_b),     32'd0);

      rst_n     = 1'b1;
      en[0]     = 1'b1;
      en[1]     = 1'b1;
      lock_hold = 20;
      repeat (1500) step();

      // Park an A transaction in WAIT_DONE, then reset asynchronously.
      en[1]      = 1'b0;
      force_hold = 1'b1;
      hit        = 1'b0;
      for (int i = 0; i < 400; i++) begin
         hit = inflight && owner == 1'b0 && !to_mode && cyc >= lock_lo + 2 && cyc < lock_hi;
         if (hit) break;
         step();
      end
      chk_eq("reach_wait_done", 32'(hit), 32'd1);

      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_eq("arst_strobe",  32'(bus.mem_strobe),  32'd0);
      chk_eq("arst_a_ack",   32'(bus.a_ack),       32'd0);
      chk_eq("arst_b_ack",   32'(bus.b_ack),       32'd0);
      chk_eq("arst_busy",    32'(bus.busy),        32'd0);
      chk_eq("arst_grant_b", 32'(bus.grant_b),     32'd0);
      chk_eq("arst_address", 32'(bus.mem_address), 32'd0);
      chk_eq("arst_wdata",   32'(bus.mem_wdata),   32'd0);
      chk_eq("arst_rdwr",    32'(bus.mem_rdwr),    32'd0);
      chk_eq("arst_a_rdata", 32'(bus.a_rdata),     32'd0);
      chk_eq("arst_b_rdata", 32'(bus.b_rdata),     32'd0);
      model_reset();
      lock_hold    = 0;
      bus.mem_lock = 1'b0;
      drive_reqs();

      repeat (2) step();
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (bus.mem_strobe) begin
            seen = 1'b1;
            break;
         end
      end
      chk_eq("rst_regrant_seen",   32'(seen),        32'd1);
      chk_eq("rst_regrant_port_a", 32'(bus.grant_b), 32'd0);

      en[1] = 1'b1;
      repeat (300) step();
      chk_eq("progress_ge_50", 32'(n_done >= 50), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Shares the single word-wide read/write host port of the SDRAM/VGA640 framebuffer controller between two requesters: port A (CPU) and port B (loader/DMA). It arbitrates round-robin and waits out the controller's lock. It issues a one-cycle strobe, tracks the lock handshake to completion, then returns read data and a one-cycle ack to the granted requester. It sits between the system bus logic and the controller's address/i_data/o_data/rdwr/clk/lock port.

Parameters:
ADDR_W, 22, word address width (matches controller address)
DATA_W, 16, data word width
ACCEPT_TIMEOUT, 8, cycles to wait for lock to rise after strobe before treating the access as completed; range 2..255

Ports:
clk  in  1  system clock, 100 MHz
rst_n  in  1  asynchronous active-low reset
a_req  in  1  port A request; held with fields stable until a_ack
a_we  in  1  port A 1=write, 0=read
a_addr  in  ADDR_W  port A word address
a_wdata  in  DATA_W  port A write data
a_ack  out  1  one-cycle completion pulse to port A
a_rdata  out  DATA_W  port A read data, valid from a_ack onward
b_req, b_we, b_addr, b_wdata, b_ack, b_rdata  same as port A, for port B
mem_address  out  ADDR_W  to controller address
mem_wdata  out  DATA_W  to controller i_data
mem_rdata  in  DATA_W  from controller o_data
mem_rdwr  out  1  to controller rdwr (1=write, 0=read)
mem_strobe  out  1  to controller clk (access strobe)
mem_lock  in  1  from controller lock (1=port unavailable / access in progress)
busy  out  1  1 in every state except IDLE
grant_b  out  1  0=A owns transaction, 1=B; valid while busy

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer = A; timeout counter = 0.
- All outputs are registered. mem_address, mem_wdata and mem_rdwr are latched at grant and held stable until the next grant.
- IDLE: if mem_lock=0 and (a_req or b_req), grant and latch the winner's fields -> ISSUE. If mem_lock=1, no grant is made and the requests wait.
- Arbitration:
  - Single requester wins.
  - Both requesting: the pointer side wins.
  - The pointer flips to the non-winner on completion (RESP).
- ISSUE: mem_strobe=1 for exactly this cycle; counter cleared -> WAIT_ACCEPT.
- WAIT_ACCEPT:
  - mem_lock=1 -> WAIT_DONE.
  - Otherwise the counter increments; at counter=ACCEPT_TIMEOUT-1 -> RESP, with mem_rdata captured if read.
- WAIT_DONE: hold until mem_lock=0; in that cycle capture mem_rdata into the granted port's rdata register (reads only) -> RESP.
- RESP: the granted port's ack=1 for one cycle; pointer flips -> IDLE.
- Ack is never asserted to the non-granted port. rdata of a port changes only on its own completed read; writes leave it unchanged.
- Minimum latency: req sampled at edge 0 -> strobe in cycle 1 -> lock seen cycle 2 -> earliest lock fall cycle 3 -> ack in cycle 4.
- A requester dropping req mid-transaction is ignored; the transaction completes and ack still pulses.
- Back-to-back: after RESP the arbiter returns to IDLE for at least one cycle before the next grant, so consecutive strobes are at least 5 cycles apart.
- mem_lock glitching high in IDLE merely defers grant; lock toggling in WAIT_DONE completes on the first 0.
- Asynchronous reset mid-operation: immediate return to reset values; the in-flight controller access is abandoned with no ack; rdata registers cleared.

Decomposition:
- Package sdram_arb_pkg: state encoding (IDLE, ISSUE, WAIT_ACCEPT, WAIT_DONE, RESP), port index constants PORT_A=0/PORT_B=1, default ADDR_W/DATA_W.
- One sub-module, rr_arbiter2: two requests plus a pointer give the winner index. It is combinational, and the pointer register lives in the parent.

Test Plan:
- Port A read at 0x001234, lock pulses high cycles 2-6, mem_rdata=16'hEFA6 when lock falls -> one strobe, mem_rdwr=0, a_ack single pulse the cycle after lock falls, a_rdata=16'hEFA6, b_ack never asserted.
- Port B write 0x3FFFFF/16'h55AA with mem_lock held 1 for 20 cycles before the request -> no strobe until lock=0. Then strobe with mem_address=0x3FFFFF, mem_wdata=16'h55AA, mem_rdwr=1, b_ack once, b_rdata unchanged.
- A and B request together from reset, both held asserted -> grants A, B, A, B in order; exactly one ack per transaction; strobes at least 5 cycles apart.
- Controller never raises lock after strobe -> RESP after ACCEPT_TIMEOUT=8 cycles, ack pulses, busy falls the cycle after ack.
- rst_n asserted while in WAIT_DONE -> all outputs 0 immediately, no ack. After release with a_req held, a fresh strobe is issued with A granted.
